membrane_spike_encoder: RTL
===========================

MEMBRANE_SPIKE_ENCODER -- requirements
Module: membrane_spike_encoder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- THRESH, 16'sh0000 (0 mV), spike detection threshold, signed Q8.8 mV.
- HYST, 16'h0A00 (10 mV), re-arm hysteresis below THRESH.
- REFRACT, 8'd4, minimum samples spent in refractory state.
- DEPTH, 4, event FIFO entries; power of two.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clock, input, 1, single clock; all state changes on its rising edge.
- reset, input, 1, asynchronous, active-low.
- v_in, input, 16, membrane potential sample, signed Q8.8 mV (-65 mV = 16'hBF00).
- v_valid, input, 1, v_in holds a new model step this cycle.
- ev_ready, input, 1, consumer accepts the head event.
- clear_ovf, input, 1, synchronous clear of ovf.
- ev_valid, output, 1, FIFO non-empty.
- ev_time, output, 16, sample index of the threshold crossing for the head event.
- ev_peak, output, 16, signed peak potential for the head event.
- spike, output, 1, one-cycle pulse on event emission.
- ovf, output, 1, sticky flag: an event was dropped.
- count, output, 3, FIFO occupancy, 0..DEPTH.

Function
REQ-003 A 16-bit sample counter ts SHALL increment by 1 on every cycle with v_valid=1 and wrap from 16'hFFFF to 0.
REQ-004 Only cycles with v_valid=1 SHALL advance the FSM; other cycles SHALL hold all state except FIFO and handshake logic.
REQ-005 All comparisons SHALL be signed 16-bit; the re-arm level SHALL be THRESH-HYST computed in 17 bits so it cannot wrap.
REQ-006 The FSM SHALL have three states: ARMED, RISING, and REFRACT.
REQ-007 ARMED: if v_in >= THRESH, the FSM SHALL go to RISING, latch t0=ts, and set peak=v_in.
REQ-008 RISING: if v_in > peak, peak SHALL update; if v_in < peak, the FSM SHALL emit event (t0, peak) and go to REFRACT with rcnt=REFRACT; if v_in == peak, the FSM SHALL stay in RISING.
REQ-009 REFRACT: rcnt SHALL decrement per sample while non-zero; when rcnt==0 and v_in < THRESH-HYST, the FSM SHALL go to ARMED; otherwise it SHALL hold.
REQ-010 Emission SHALL assert spike for exactly one cycle, the cycle after the emitting sample, and push to the FIFO in that same cycle; ev_valid SHALL reflect the push one cycle later.
REQ-011 FIFO handshake: the head SHALL pop when ev_valid&&ev_ready; ev_time and ev_peak SHALL be stable while ev_valid=1 and ev_ready=0.
REQ-012 On a push while full with no pop, the event SHALL be dropped, ovf SHALL be set, and count SHALL remain DEPTH.
REQ-013 On a simultaneous push and pop while full, both SHALL succeed, count SHALL remain DEPTH, and ovf SHALL be unchanged.
REQ-014 On a simultaneous push and pop while empty, the push SHALL land and count SHALL become 1.
REQ-015 clear_ovf SHALL clear ovf; if a drop coincides with clear_ovf, the set SHALL win.

Reset
REQ-016 On reset low, asynchronously: FSM=ARMED, ts=0, t0=0, peak=0, rcnt=0, FIFO empty, and outputs ev_valid=0, spike=0, ovf=0, count=0, ev_time=0, ev_peak=0.
REQ-017 Reset mid-spike SHALL discard the in-progress event and all queued events; no spike pulse SHALL follow the release of reset.

Structure
REQ-018 The shared neuron package SHALL hold the Q8.8 voltage type, the constants V_REST=16'hBF00 and V_ZERO, and the FSM state encoding.
REQ-019 The FIFO SHALL be one sub-module, spike_event_fifo (32-bit entries {time, peak}, parameter DEPTH); FSM and counters SHALL live in the top module.

Verification
REQ-020 Samples -65, -30, 5, 20, 35, 30, -70 mV at ts 0..6 -> one spike with ev_time=2, ev_peak=16'h2300, and ev_valid high two cycles after the sample at ts 5.
REQ-021 A second rise to 10 mV at ts 8, with ts 7 = -70 mV -> no event, because the REFRACT count is not exhausted.
REQ-022 Potential held at -5 mV after a spike (inside the hysteresis band) -> never re-arms, and no event follows a later rise to 20 mV.
REQ-023 Five spikes with ev_ready=0 -> count=4, ovf=1, and the first four events are read back in order; clear_ovf -> ovf=0.
REQ-024 FIFO full with ev_ready=1 in the same cycle a spike emits -> count stays 4, ovf stays 0, and the new event is last out.
REQ-025 Reset pulsed low while in RISING at 20 mV -> count=0 and ev_valid=0 immediately; no spike follows the release.

Source files
------------

// File: rtl/membrane_spike_encoder_pkg.sv
// Shared neuron package.
// Holds the signed Q8.8 millivolt voltage type, common voltage constants,
// the spike-detector FSM state encoding and the event packing helper used
// by the encoder and its event FIFO.
package membrane_spike_encoder_pkg;

  // Signed Q8.8 membrane potential in mV (8 integer bits, 8 fractional bits).
  typedef logic signed [15:0] volt_t;

  // -65 mV resting potential and the 0 mV reference.
  localparam volt_t V_REST = 16'shBF00;
  localparam volt_t V_ZERO = 16'sh0000;

  // Width of one queued event: {time[15:0], peak[15:0]}.
  localparam int EV_W = 32;

  typedef enum logic [1:0] {
    ST_ARMED   = 2'd0,
    ST_RISING  = 2'd1,
    ST_REFRACT = 2'd2
  } state_t;

  function automatic logic [EV_W-1:0] pack_event(input logic [15:0] t, input volt_t p);
    return {t, p};
  endfunction

endpackage

// File: rtl/spike_event_fifo.sv
// Event FIFO for the spike encoder.
// Stores 32-bit events {time, peak}. A push that finds the FIFO full with no
// pop in the same cycle is dropped and sets a sticky overflow flag; a push
// and pop together while full both take effect.
// Ports:
//   clock, reset (async active-low)
//   push, din       : write request and event data
//   pop             : read request (ignored when empty)
//   clear_ovf       : synchronous clear of ovf (a coincident drop wins)
//   dout            : head event, forced to zero while empty
//   empty, count    : occupancy status, count in 0..DEPTH
//   ovf             : sticky drop flag
module spike_event_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [31:0]              din,
  input  logic                     pop,
  input  logic                     clear_ovf,
  output logic [31:0]              dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          full;
  logic          do_pop;
  logic          do_push;
  logic          drop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  assign count = cnt;
  assign dout  = empty ? 32'd0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        cnt <= cnt + 1'b1;
      end else if (!do_push && do_pop) begin
        cnt <= cnt - 1'b1;
      end
      // Set has priority over clear so a drop is never lost.
      if (drop) begin
        ovf <= 1'b1;
      end else if (clear_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/membrane_spike_encoder.sv
// Membrane spike encoder.
// Watches a stream of signed Q8.8 membrane samples, detects threshold
// crossings, tracks the peak of each spike and queues {crossing time, peak}
// events in a small FIFO for a downstream consumer.
// Handshake: an event leaves the FIFO head on a cycle where ev_valid and
// ev_ready are both high; while ev_valid is high and ev_ready is low the
// head (ev_time, ev_peak) holds steady.
// Ports:
//   clock, reset (async active-low)
//   v_in, v_valid   : sample and its strobe; only strobed cycles advance
//                     the sample counter and the FSM
//   ev_ready        : consumer accepts the head event
//   clear_ovf       : synchronous clear of ovf
//   ev_valid        : FIFO non-empty
//   ev_time, ev_peak: head event fields (zero when empty)
//   spike           : one-cycle pulse in the cycle the event is pushed
//   ovf             : sticky, an event was dropped on a full FIFO
//   count           : FIFO occupancy
//   dbg_state       : current FSM state
module membrane_spike_encoder
  import membrane_spike_encoder_pkg::*;
#(
  parameter volt_t      THRESH  = 16'sh0000,
  parameter logic [15:0] HYST   = 16'h0A00,
  parameter logic [7:0] REFRACT = 8'd4,
  parameter int         DEPTH   = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [15:0]            v_in,
  input  logic                   v_valid,
  input  logic                   ev_ready,
  input  logic                   clear_ovf,
  output logic                   ev_valid,
  output logic [15:0]            ev_time,
  output logic [15:0]            ev_peak,
  output logic                   spike,
  output logic                   ovf,
  output logic [$clog2(DEPTH):0] count,
  output logic [1:0]             dbg_state
);

  // Re-arm level in 17 bits so a very negative THRESH cannot wrap positive.
  localparam logic signed [16:0] REARM =
    $signed({THRESH[15], THRESH}) - $signed({1'b0, HYST});

  state_t             state;
  logic [15:0]        ts;
  logic [15:0]        t0;
  volt_t              peak;
  logic [7:0]         rcnt;
  logic               emit_q;
  logic [31:0]        emit_data;
  volt_t              v_s;
  logic signed [16:0] v_ext;
  logic               fifo_empty;
  logic [31:0]        head;
  logic               pop;

  assign v_s   = $signed(v_in);
  assign v_ext = v_s;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_ARMED;
      ts        <= 16'd0;
      t0        <= 16'd0;
      peak      <= V_ZERO;
      rcnt      <= 8'd0;
      emit_q    <= 1'b0;
      emit_data <= 32'd0;
    end else begin
      emit_q <= 1'b0;
      if (v_valid) begin
        ts <= ts + 16'd1;
        case (state)
          ST_ARMED: begin
            if (v_s >= THRESH) begin
              state <= ST_RISING;
              t0    <= ts;
              peak  <= v_s;
            end
          end
          ST_RISING: begin
            if (v_s > peak) begin
              peak <= v_s;
            end else if (v_s < peak) begin
              // The first falling sample closes the spike; it is pushed
              // and announced on the following cycle.
              emit_q    <= 1'b1;
              emit_data <= pack_event(t0, peak);
              state     <= ST_REFRACT;
              rcnt      <= REFRACT;
            end
          end
          ST_REFRACT: begin
            if (rcnt != 8'd0) begin
              rcnt <= rcnt - 8'd1;
            end else if (v_ext < REARM) begin
              state <= ST_ARMED;
            end
          end
          default: state <= ST_ARMED;
        endcase
      end
    end
  end

  assign spike     = emit_q;
  assign pop       = ev_valid && ev_ready;
  assign ev_valid  = !fifo_empty;
  assign ev_time   = head[31:16];
  assign ev_peak   = head[15:0];
  assign dbg_state = state;

  spike_event_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (emit_q),
    .din       (emit_data),
    .pop       (pop),
    .clear_ovf (clear_ovf),
    .dout      (head),
    .empty     (fifo_empty),
    .count     (count),
    .ovf       (ovf)
  );

endmodule
